spart_bus_ctrl: RTL and testbench

- Sequencer and owner of the SPART processor bus (iocs/iorw/ioaddr/databus). It programs the baud divisor from br_cfg after reset and on any br_cfg change.
- It drains a 4-entry client TX FIFO into the SPART when tbr is high, and moves received bytes from the SPART into a client-facing holding register.
- It is the only master on the SPART bus and sits between the SPART and any byte-level client logic.

---
 rtl/spart_bus_pkg.sv | 37 +++
 rtl/spart_bus_ctrl_if.sv | 20 ++
 rtl/spart_txfifo.sv | 61 ++++++
 rtl/spart_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_spart_bus_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_bus_pkg.sv
// Shared definitions for the SPART bus controller.
//   - SPART register address encoding
//   - controller state encoding (plain constants, legacy-compatible)
//   - baud divisor constants for a 100 MHz clock, 16x oversampling
//   - br_divisor(): maps the 2-bit baud select to its divisor
package spart_bus_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;  // TX/RX buffer
    localparam logic [1:0] ADDR_STAT = 2'b01;  // status
    localparam logic [1:0] ADDR_DBL  = 2'b10;  // divisor low byte
    localparam logic [1:0] ADDR_DBH  = 2'b11;  // divisor high byte

    typedef logic [2:0] state_t;
    localparam state_t ST_CFG_LO = 3'd0;
    localparam state_t ST_CFG_HI = 3'd1;
    localparam state_t ST_IDLE   = 3'd2;
    localparam state_t ST_RX     = 3'd3;
    localparam state_t ST_TX     = 3'd4;

    // 100 MHz / (16 * baud) - 1
    localparam logic [15:0] DIV_4800  = 16'h0515;
    localparam logic [15:0] DIV_9600  = 16'h028A;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A2;

    function automatic logic [15:0] br_divisor(input logic [1:0] sel);
        logic [15:0] div;
        case (sel)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/spart_bus_ctrl_if.sv
// SPART processor bus control/status signals.
//   iocs   : chip select, one-cycle pulse per access
//   iorw   : 1 = read, 0 = write
//   ioaddr : register address (see spart_bus_pkg ADDR_*)
//   rda    : SPART receive data available
//   tbr    : SPART transmit buffer ready
// The 8-bit databus is bidirectional and is carried as a plain inout port.
// Modports: master = bus controller, slave = SPART.
interface spart_bus_ctrl_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_txfifo.sv
// Synchronous FIFO holding client TX bytes.
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : write request/data; ignored when full unless popping too
//   pop, rdata    : read request; rdata is the current head (show-ahead)
//   full, empty   : occupancy flags
//   count         : number of stored entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module spart_txfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: sole master of the SPART processor bus.
// Programs the baud divisor after reset and whenever br_cfg changes, drains
// the client TX FIFO into the SPART while tbr is high, and moves received
// bytes into a client-facing holding register.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   br_cfg            : baud select (asynchronous, synchronized here)
//   bus               : spart_bus_ctrl_if.master (iocs/iorw/ioaddr, rda/tbr)
//   databus           : bidirectional data, driven only during write accesses
//   tx_valid/tx_data/tx_ready : client push into the TX FIFO
//   rx_valid/rx_data/rx_ready : received byte holding register
//   cfg_done          : divisor programmed for the current br_cfg
//   echo_drop         : (SPART_BUS_CTRL_ECHO_EN only) sticky, an echo was lost
// Optional build macro SPART_BUS_CTRL_ECHO_EN: every received byte is also
// pushed into the TX FIFO.
module spart_bus_ctrl
    import spart_bus_pkg::*;
#(
    parameter int unsigned TXF_DEPTH = 4,
    parameter int unsigned GUARD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       br_cfg,
    spart_bus_ctrl_if.master bus,
    inout  wire  [7:0]       databus,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    input  logic             rx_ready,
    output logic             cfg_done
`ifdef SPART_BUS_CTRL_ECHO_EN
    ,
    output logic             echo_drop
`endif
);

    localparam int unsigned CW = $clog2(TXF_DEPTH) + 1;
    localparam int unsigned GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

    logic [1:0]    br_s1, br_s2;
    logic [1:0]    sync_ok_q;
    logic [1:0]    br_prog_q, br_prog_d;
    state_t        state_q, state_d;
    logic          iocs_q, iocs_d;
    logic          iorw_q, iorw_d;
    logic [1:0]    ioaddr_q, ioaddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [GW-1:0] txg_q, txg_d;
    logic [GW-1:0] rxg_q, rxg_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          cfg_done_q, cfg_done_d;
    logic          tx_ready_q, tx_ready_d;

    logic          br_change, cfg_ok, rd_done, dbh_done, rx_go, tx_go;
    logic [15:0]   div_new, div_prog;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_wdata, fifo_rdata;
    logic [CW-1:0] fifo_count, cnt_next;
    logic          push_eff, pop_eff;

    // Bus outputs are registered; the access happens the cycle after its state.
    assign bus.iocs   = iocs_q;
    assign bus.iorw   = iorw_q;
    assign bus.ioaddr = ioaddr_q;
    assign databus    = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;

    assign br_change = (br_s2 != br_prog_q);
    assign cfg_ok    = cfg_done_q & ~br_change;
    assign cfg_done  = cfg_ok;
    assign rd_done   = iocs_q & iorw_q & (ioaddr_q == ADDR_BUF);
    assign dbh_done  = iocs_q & ~iorw_q & (ioaddr_q == ADDR_DBH);
    assign div_new   = br_divisor(br_s2);
    assign div_prog  = br_divisor(br_prog_q);

    assign rx_go = cfg_ok & bus.rda & (rxg_q == '0) & (~rx_valid_q | rx_ready);
    assign tx_go = cfg_ok & bus.tbr & (txg_q == '0) & ~fifo_empty;

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

`ifdef SPART_BUS_CTRL_ECHO_EN
    logic echo_drop_q;
    // The echo owns the FIFO write port in a read-completion cycle.
    assign tx_ready   = tx_ready_q & ~rd_done;
    assign fifo_push  = rd_done | (tx_valid & tx_ready);
    assign fifo_wdata = rd_done ? databus : tx_data;
    assign echo_drop  = echo_drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_drop_q <= 1'b0;
        end else if (rd_done && fifo_full && !fifo_pop) begin
            echo_drop_q <= 1'b1;
        end
    end
`else
    assign tx_ready   = tx_ready_q;
    assign fifo_push  = tx_valid & tx_ready;
    assign fifo_wdata = tx_data;
`endif

    spart_txfifo #(
        .DEPTH (TXF_DEPTH),
        .WIDTH (8)
    ) u_txfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy after this cycle's push/pop, used to register tx_ready.
    always_comb begin
        push_eff = fifo_push & (~fifo_full | (fifo_pop & ~fifo_empty));
        pop_eff  = fifo_pop & ~fifo_empty;
        cnt_next = fifo_count;
        if (push_eff && !pop_eff) begin
            cnt_next = fifo_count + CW'(1);
        end else if (!push_eff && pop_eff) begin
            cnt_next = fifo_count - CW'(1);
        end
        tx_ready_d = (cnt_next != CW'(TXF_DEPTH));
    end

    always_comb begin
        state_d   = state_q;
        iocs_d    = 1'b0;
        iorw_d    = 1'b1;
        ioaddr_d  = ADDR_BUF;
        wdata_d   = wdata_q;
        br_prog_d = br_prog_q;
        fifo_pop  = 1'b0;
        txg_d     = (txg_q != '0) ? txg_q - GW'(1) : txg_q;
        rxg_d     = (rxg_q != '0) ? rxg_q - GW'(1) : rxg_q;
        case (state_q)
            ST_CFG_LO: begin
                // Wait until the synchronizer holds a post-reset value.
                if (sync_ok_q[1]) begin
                    iocs_d    = 1'b1;
                    iorw_d    = 1'b0;
                    ioaddr_d  = ADDR_DBL;
                    wdata_d   = div_new[7:0];
                    br_prog_d = br_s2;
                    state_d   = ST_CFG_HI;
                end
            end
            ST_CFG_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DBH;
                wdata_d  = div_prog[15:8];
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (br_change) begin
                    state_d = ST_CFG_LO;
                end else if (rx_go) begin
                    state_d = ST_RX;
                end else if (tx_go) begin
                    state_d = ST_TX;
                end
            end
            ST_RX: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b1;
                ioaddr_d = ADDR_BUF;
                rxg_d    = GW'(GUARD_CYC);
                state_d  = ST_IDLE;
            end
            ST_TX: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_BUF;
                wdata_d  = fifo_rdata;
                fifo_pop = 1'b1;
                txg_d    = GW'(GUARD_CYC);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_CFG_LO;
        endcase
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (rd_done) begin
            rx_data_d  = databus;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        cfg_done_d = cfg_done_q;
        if (br_change) begin
            cfg_done_d = 1'b0;
        end else if (dbh_done) begin
            cfg_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_s1      <= 2'b00;
            br_s2      <= 2'b00;
            sync_ok_q  <= 2'b00;
            br_prog_q  <= 2'b00;
            state_q    <= ST_CFG_LO;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= ADDR_BUF;
            wdata_q    <= 8'h00;
            txg_q      <= '0;
            rxg_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            cfg_done_q <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            br_s1      <= br_cfg;
            br_s2      <= br_s1;
            sync_ok_q  <= {sync_ok_q[0], 1'b1};
            br_prog_q  <= br_prog_d;
            state_q    <= state_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            wdata_q    <= wdata_d;
            txg_q      <= txg_d;
            rxg_q      <= rxg_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            cfg_done_q <= cfg_done_d;
            tx_ready_q <= tx_ready_d;
        end
    end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Testbench for spart_bus_ctrl. Bus accesses and accepted RX bytes are
// checked by monitor threads against scoreboard queues filled by the
// stimulus. Build with SPART_BUS_CTRL_ECHO_EN to exercise the echo path.
module tb_spart_bus_ctrl;
    import spart_bus_pkg::*;

    localparam int GUARD = 2;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       cfg_done;
    logic [7:0] spart_byte = 8'h00;
    wire  [7:0] databus;
`ifdef SPART_BUS_CTRL_ECHO_EN
    logic       echo_drop;
`endif

    spart_bus_ctrl_if bus ();

    // SPART model: answers reads, otherwise drives a fixed pattern so a
    // released DUT bus reads back as 0xA5.
    assign databus = (bus.iocs && !bus.iorw) ? 8'hzz : (bus.iocs ? spart_byte : 8'hA5);

    spart_bus_ctrl #(
        .TXF_DEPTH (4),
        .GUARD_CYC (GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .bus      (bus),
        .databus  (databus),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .cfg_done (cfg_done)
`ifdef SPART_BUS_CTRL_ECHO_EN
        ,
        .echo_drop (echo_drop)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    acc_t exp_acc[$];
    logic [7:0] exp_rx[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bus(input logic rw, input logic [1:0] addr, input logic [7:0] data);
        acc_t a;
        a.rw   = rw;
        a.addr = addr;
        a.data = data;
        exp_acc.push_back(a);
    endtask

    task automatic wait_acc(input int max_cyc, input string what);
        int n = 0;
        while (exp_acc.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check(what, exp_acc.size(), 0);
    endtask

    task automatic wait_cfg(input int max_cyc, input string what);
        int n = 0;
        while (cfg_done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check(what, cfg_done, 1);
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n, input int n_accept);
        for (int i = 0; i < n; i++) begin
            tx_valid = 1'b1;
            tx_data  = first + 8'(i);
            check("tx_ready_on_push", tx_ready, 32'(i < n_accept));
            tick();
        end
        tx_valid = 1'b0;
    endtask

    task automatic accept_rx();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Bus monitor: every iocs cycle must match the next expected access.
    task automatic mon_bus();
        acc_t got;
        acc_t want;
        int   dbl_cyc = -100;
        int   dbh_cyc = -100;
        int   txw_cyc = -100;
        logic cfg_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bus.iocs) begin
                got.rw   = bus.iorw;
                got.addr = bus.ioaddr;
                got.data = databus;
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL bus_unexpected: got rw=%0b addr=%0d data=0x%02h, required no access",
                             got.rw, got.addr, got.data);
                end else begin
                    want = exp_acc.pop_front();
                    check("bus_access", 32'(got), 32'(want));
                end
                if (!got.rw && got.addr == ADDR_DBL) dbl_cyc = cyc;
                if (!got.rw && got.addr == ADDR_DBH) begin
                    dbh_cyc = cyc;
                    check("cfg_writes_consecutive", cyc - dbl_cyc, 1);
                end
                if (!got.rw && got.addr == ADDR_BUF) begin
                    if (cyc - txw_cyc < 50) check("tx_spacing_ok", 32'(cyc - txw_cyc >= GUARD + 1), 1);
                    txw_cyc = cyc;
                end
            end
            if (rst && cfg_done && !cfg_prev) check("cfg_done_after_dbh", cyc - dbh_cyc, 1);
            cfg_prev = rst ? cfg_done : 1'b0;
        end
    endtask

    // RX monitor: checks each accepted byte against the expected stream.
    task automatic mon_rx();
        forever begin
            @(negedge clk);
            if (rst && rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got 0x%02h, required no byte", rx_data);
                end else begin
                    check("rx_byte", rx_data, exp_rx.pop_front());
                end
            end
        end
    endtask

    initial begin
        bus.rda = 1'b0;
        bus.tbr = 1'b0;
        fork
            mon_bus();
            mon_rx();
        join_none

        // Reset values.
        tick();
        check("rst_iocs", bus.iocs, 0);
        check("rst_iorw", bus.iorw, 1);
        check("rst_ioaddr", bus.ioaddr, 0);
        check("rst_databus_released", databus, 8'hA5);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_cfg_done", cfg_done, 0);

        // Initial divisor programming for 9600 baud.
        exp_bus(1'b0, ADDR_DBL, 8'h8A);
        exp_bus(1'b0, ADDR_DBH, 8'h02);
        rst = 1'b1;
        wait_acc(20, "cfg_9600_writes");
        wait_cfg(20, "cfg_9600_done");

        // Reconfigure to 38400 while idle.
        exp_bus(1'b0, ADDR_DBL, 8'hA2);
        exp_bus(1'b0, ADDR_DBH, 8'h00);
        br_cfg = 2'b11;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cfg_done_low_during_reprog", cfg_done, 0);
        end
        wait_acc(20, "cfg_38400_writes");
        wait_cfg(20, "cfg_38400_done");

        // Fill the FIFO with tbr low, then drain in order.
        push_bytes(8'h41, 5, 4);
        check("tx_ready_full", tx_ready, 0);
        for (int i = 0; i < 4; i++) exp_bus(1'b0, ADDR_BUF, 8'h41 + 8'(i));
        bus.tbr = 1'b1;
        wait_acc(60, "tx_drain");
        bus.tbr = 1'b0;
        tick();
        check("tx_ready_after_drain", tx_ready, 1);

        // RX backpressure: one read only while the holding register is full.
        spart_byte = 8'h5A;
        exp_bus(1'b1, ADDR_BUF, 8'h5A);
        bus.rda = 1'b1;
        repeat (12) tick();
        check("rx_valid_held", rx_valid, 1);
        check("rx_data_5a", rx_data, 8'h5A);
        spart_byte = 8'h5B;
        exp_bus(1'b1, ADDR_BUF, 8'h5B);
        exp_rx.push_back(8'h5A);
        accept_rx();
        repeat (12) tick();
        bus.rda = 1'b0;
        check("rx_data_5b", rx_data, 8'h5B);
        exp_rx.push_back(8'h5B);
        accept_rx();
        check("rx_valid_cleared", rx_valid, 0);

`ifdef SPART_BUS_CTRL_ECHO_EN
        // Clear the FIFO of earlier echoes, then test the echo path.
        rst = 1'b0;
        tick();
        exp_bus(1'b0, ADDR_DBL, 8'hA2);
        exp_bus(1'b0, ADDR_DBH, 8'h00);
        rst = 1'b1;
        wait_acc(20, "echo_cfg_writes");
        wait_cfg(20, "echo_cfg_done");
        check("echo_drop_reset", echo_drop, 0);
        spart_byte = 8'h33;
        exp_bus(1'b1, ADDR_BUF, 8'h33);
        bus.rda = 1'b1;
        repeat (8) tick();
        bus.rda = 1'b0;
        check("echo_rx_data", rx_data, 8'h33);
        exp_bus(1'b0, ADDR_BUF, 8'h33);
        bus.tbr = 1'b1;
        wait_acc(30, "echo_tx_write");
        bus.tbr = 1'b0;
        exp_rx.push_back(8'h33);
        accept_rx();
        push_bytes(8'hC0, 4, 4);
        check("echo_fifo_full", tx_ready, 0);
        spart_byte = 8'h44;
        exp_bus(1'b1, ADDR_BUF, 8'h44);
        bus.rda = 1'b1;
        repeat (8) tick();
        bus.rda = 1'b0;
        check("echo_drop_set", echo_drop, 1);
        exp_rx.push_back(8'h44);
        accept_rx();
`else
        // RX beats TX; then reset in the middle of the TX write.
        push_bytes(8'h77, 2, 2);
        spart_byte = 8'h99;
        exp_bus(1'b1, ADDR_BUF, 8'h99);
        exp_bus(1'b0, ADDR_BUF, 8'h77);
        bus.rda = 1'b1;
        bus.tbr = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus.iocs && !bus.iorw) && n < 30);
            check("tx_write_seen", 32'(bus.iocs && !bus.iorw), 1);
        end
        check("rx_before_tx_data", rx_data, 8'h99);
        check("rx_before_tx_valid", rx_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_iocs", bus.iocs, 0);
        check("midrst_databus_released", databus, 8'hA5);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_cfg_done", cfg_done, 0);
        bus.rda = 1'b0;
        exp_bus(1'b0, ADDR_DBL, 8'hA2);
        exp_bus(1'b0, ADDR_DBH, 8'h00);
        tick();
        rst = 1'b1;
        wait_acc(20, "midrst_cfg_writes");
        wait_cfg(20, "midrst_cfg_done");
        // FIFO must be empty: no write of 0x78 may appear with tbr high.
        repeat (20) tick();
        bus.tbr = 1'b0;
`endif

        repeat (4) tick();
        check("acc_queue_drained", exp_acc.size(), 0);
        check("rx_queue_drained", exp_rx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
